// File: rtl/pwm8_pkg.sv
// Constants shared by the LED PWM driver and the PWM duty decoder so that
// both ends agree on the PWM period and the saturation limit.
package pwm8_pkg;

    localparam int PWM_WIDTH    = 8;
    localparam int PWM_CHANNELS = 8;
    localparam int PWM_PERIOD   = 1 << PWM_WIDTH;
    localparam int PWM_MAX      = PWM_PERIOD - 1;

endpackage

// File: rtl/pwm_chan_meas.sv
// Single-channel duty measurement: a 2-flop synchronizer, a high-time counter
// and a change detector, with the result latched at the end of each window.
module pwm_chan_meas #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             win_end,
    input  logic             in,
    output logic [WIDTH-1:0] val,
    output logic             toggling
);

    logic             sync_q;
    logic             s;
    logic             prev;
    logic             tog;
    logic [WIDTH:0]   hcnt;
    logic [WIDTH:0]   hsum;
    logic             changed;

    assign hsum    = hcnt + {{WIDTH{1'b0}}, s};
    assign changed = (s != prev);

    // The synchronizer free-runs; only the accumulation honours en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_q <= in;
            s      <= sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt     <= '0;
            prev     <= 1'b0;
            tog      <= 1'b0;
            val      <= '0;
            toggling <= 1'b0;
        end else if (en) begin
            prev <= s;
            if (win_end) begin
                // A full window of highs gives 2^WIDTH, which clamps to the max code.
                val      <= hsum[WIDTH] ? {WIDTH{1'b1}} : hsum[WIDTH-1:0];
                toggling <= tog | changed;
                hcnt     <= '0;
                tog      <= 1'b0;
            end else begin
                hcnt <= hsum;
                if (changed) begin
                    tog <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm8_decode.sv
// Eight-channel PWM duty decoder: measures each input's high time over a
// window of 2^WIDTH enabled clocks and strobes the results out with valid.
module pwm8_decode
    import pwm8_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int CHANNELS = PWM_CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       in,
    output logic [CHANNELS*WIDTH-1:0] val,
    output logic                      valid,
    output logic [CHANNELS-1:0]       toggling
);

    logic [WIDTH-1:0] wcnt;
    logic             win_end;

    assign win_end = en && (wcnt == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= win_end;
            if (en) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pwm_chan_meas #(
            .WIDTH (WIDTH)
        ) u_meas (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .win_end  (win_end),
            .in       (in[i]),
            .val      (val[i*WIDTH +: WIDTH]),
            .toggling (toggling[i])
        );
    end

endmodule

// File: tb/tb_pwm8_decode.sv
// Directed bench for pwm8_decode: a window-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_pwm8_decode;

    localparam int W  = 8;
    localparam int CH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [CH-1:0]   in;
    logic [CH*W-1:0] val;
    logic            valid;
    logic [CH-1:0]   toggling;

    int checks = 0;
    int errors = 0;

    pwm8_decode #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in       (in),
        .val      (val),
        .valid    (valid),
        .toggling (toggling)
    );

    always #5 clk = ~clk;

    // Model: samples lag inputs by two edges; each window of 256 enabled
    // samples yields min(highs,255) and whether any level change occurred.
    logic [CH-1:0]   pipe[$];
    logic [CH-1:0]   samp, m_prev, m_tog;
    int              m_cnt[CH];
    int              m_wc;
    logic [CH*W-1:0] e_val;
    logic [CH-1:0]   e_tog;
    logic            e_valid;
    bit              started = 0;

    always @(posedge clk) begin
        if (rst) begin
            pipe = {};
            pipe.push_back('0);
            pipe.push_back('0);
            m_prev = '0; m_tog = '0; m_wc = 0;
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
            e_val = '0; e_tog = '0; e_valid = 1'b0;
            started = 1;
        end else if (started) begin
            samp = pipe.pop_front();
            pipe.push_back(in);
            e_valid = 1'b0;
            if (en) begin
                for (int i = 0; i < CH; i++) if (samp[i]) m_cnt[i]++;
                m_tog  = m_tog | (samp ^ m_prev);
                m_prev = samp;
                m_wc++;
                if (m_wc == 256) begin
                    for (int i = 0; i < CH; i++)
                        e_val[i*W +: W] = W'((m_cnt[i] > 255) ? 255 : m_cnt[i]);
                    e_tog   = m_tog;
                    e_valid = 1'b1;
                    m_tog   = '0;
                    m_wc    = 0;
                    for (int i = 0; i < CH; i++) m_cnt[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ({valid, val, toggling} !== {e_valid, e_val, e_tog}) begin
                errors++;
                $display("FAIL model t=%0t valid %b/%b val %h/%h tog %h/%h",
                         $time, valid, e_valid, val, e_val, toggling, e_tog);
            end
        end
    end

    // Stimulus: a bench-side PWM driver counter shared across channels.
    int  pc;
    int  duty[CH];
    bit  pulse5;
    bit  en_rand;
    bit  en_on;
    logic en_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        logic [CH-1:0] v;
        en = en_rand ? 1'($urandom_range(0, 1)) : en_on;
        for (int i = 0; i < CH; i++) v[i] = (pc < duty[i]);
        if (pulse5) v[5] = (pc == 0);
        in = v;
        if (en) pc = (pc + 1) % 256;
    endtask

    task automatic step(output logic got);
        @(negedge clk);
        got     = valid;
        en_last = en;
        drive();
    endtask

    task automatic wait_valid(output int n);
        logic got;
        for (n = 1; n <= 1200; n++) begin
            step(got);
            if (got) return;
        end
        errors++;
        $display("FAIL wait_valid timeout");
        n = -1;
    endtask

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3,
                            input int d7);
        for (int i = 0; i < CH; i++) duty[i] = 0;
        duty[0] = d0; duty[1] = d1; duty[2] = d2; duty[3] = d3; duty[7] = d7;
    endtask

    logic [CH*W-1:0] exp_v;
    int              n;
    logic            g;

    initial begin
        rst = 1'b1; en = 1'b0; in = '0;
        pc = 0; pulse5 = 0; en_rand = 0; en_on = 0; en_last = 0;
        for (int i = 0; i < CH; i++) duty[i] = 256;
        repeat (2) step(g);
        chk("reset_valid", 64'(valid), 64'(0));
        chk("reset_val", 64'(val), 64'(0));
        chk("reset_tog", 64'(toggling), 64'(0));

        // All high: let the synchronizer fill before enabling.
        rst = 1'b0;
        repeat (3) step(g);
        en_on = 1;
        for (int w = 0; w < 3; w++) begin
            wait_valid(n);
            chk("ones_val", 64'(val), {8{8'hFF}});
            chk("ones_tog", 64'(toggling), (w == 0) ? 64'hFF : 64'h00);
        end

        // All low; skip the window that straddles the change.
        for (int i = 0; i < CH; i++) duty[i] = 0;
        wait_valid(n);
        wait_valid(n);
        chk("zeros_val", 64'(val), 64'(0));
        chk("zeros_tog", 64'(toggling), 64'(0));
        wait_valid(n);
        chk("zeros_period", 64'(n), 64'(256));
        chk("zeros_val2", 64'(val), 64'(0));
        step(g);
        chk("valid_width", 64'(g), 64'(0));

        // Loopback with random phase.
        set_duty(128, 1, 255, 0, 0);
        pc = $urandom_range(0, 255);
        wait_valid(n);
        for (int w = 0; w < 2; w++) begin
            wait_valid(n);
            exp_v = '0;
            exp_v[0 +: 8] = 8'd128; exp_v[8 +: 8] = 8'd1; exp_v[16 +: 8] = 8'd255;
            chk("loop_val", 64'(val), 64'(exp_v));
            chk("loop_tog", 64'(toggling), 64'h07);
        end

        // ch3 at 64 with random enable; valid only after an enabled cycle.
        set_duty(0, 0, 0, 64, 0);
        en_rand = 1;
        for (int w = 0; w < 3; w++) begin
            wait_valid(n);
            chk("rand_en_before_valid", 64'(en_last), 64'(1));
        end
        en_rand = 0;

        // Reset mid-window at wcnt=100 with ch0 at 200.
        set_duty(200, 0, 0, 0, 0);
        wait_valid(n);
        for (int k = 0; k < 600 && m_wc != 100; k++) step(g);
        chk("rst_at_wcnt", 64'(m_wc), 64'(100));
        @(negedge clk);
        rst = 1'b1; pc = 220; drive();
        @(negedge clk);
        chk("rst_mid_valid", 64'(valid), 64'(0));
        chk("rst_mid_val", 64'(val), 64'(0));
        rst = 1'b0; drive();
        wait_valid(n);
        chk("rst_first_valid_delay", 64'(n), 64'(256));
        chk("rst_ch0_val", 64'(val[7:0]), 64'(200));

        // Single one-cycle pulse per period on ch5.
        set_duty(0, 0, 0, 0, 0);
        pulse5 = 1;
        wait_valid(n);
        wait_valid(n);
        exp_v = '0;
        exp_v[40 +: 8] = 8'd1;
        chk("pulse_val", 64'(val), 64'(exp_v));
        chk("pulse_tog", 64'(toggling), 64'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
